// File: rtl/kbd_letter_display.sv
// PS/2 set-2 keyboard receiver that collects typed letters A..Z into a small
// shift buffer and scans them onto a multiplexed, active-low digit display.
module kbd_letter_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kbdclk,
    input  logic              kbddat,
    input  logic              clr,
    output logic [DIGITS-1:0] an,
    output logic [4:0]        digit_code,
    output logic [4:0]        last_letter,
    output logic              letter_stb,
    output logic              frame_err,
    output logic [3:0]        count
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int EW = 5 * DIGITS;
    localparam logic [4:0] BLANK = 5'd31;

    typedef enum logic [1:0] {IDLE, BREAK, EXT} state_t;

    logic          kc_s1, kc_s2, kc_prev, kd_s1, kd_s2;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [10:0]   shreg;
    logic          frame_done, frame_ok, byte_vld;
    logic [7:0]    rx_byte;
    logic [TW-1:0] idle_cnt;
    state_t        state, state_n;
    logic          is_letter, do_letter, do_bksp;
    logic [4:0]    code;
    logic [EW-1:0] ents, push_n, pop_n;
    logic [RW-1:0] rcnt;
    logic [IW-1:0] idx, idx_n;
    logic          wrap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {kc_s1, kc_s2, kc_prev, kd_s1, kd_s2} <= '1;
        end else begin
            kc_s1   <= kbdclk;
            kc_s2   <= kc_s1;
            kc_prev <= kc_s2;
            kd_s1   <= kbddat;
            kd_s2   <= kd_s1;
        end
    end

    assign fall = kc_prev & ~kc_s2;

    // Bits shift in at the MSB so after 11 samples: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            idle_cnt   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= frame_done & ~frame_ok;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!kd_s2) begin
                        bit_cnt <= 4'd1;
                        shreg   <= {kd_s2, shreg[10:1]};
                    end
                end else begin
                    shreg <= {kd_s2, shreg[10:1]};
                    if (bit_cnt == 4'd10) begin
                        bit_cnt    <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    assign frame_ok = ~shreg[0] & shreg[10] & (^shreg[9:1]);
    assign byte_vld = frame_done & frame_ok;
    assign rx_byte  = shreg[8:1];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (byte_vld) begin
            case (state)
                IDLE:    if (rx_byte == 8'hF0) state_n = BREAK;
                         else if (rx_byte == 8'hE0) state_n = EXT;
                BREAK:   state_n = IDLE;
                EXT:     state_n = (rx_byte == 8'hF0) ? BREAK : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        do_letter = byte_vld && (state == IDLE) && is_letter;
        do_bksp   = byte_vld && (state == IDLE) && (rx_byte == 8'h66);
    end

    always_comb begin
        is_letter = 1'b1;
        code      = BLANK;
        case (rx_byte)
            8'h1C: code = 5'd0;   8'h32: code = 5'd1;   8'h21: code = 5'd2;
            8'h23: code = 5'd3;   8'h24: code = 5'd4;   8'h2B: code = 5'd5;
            8'h34: code = 5'd6;   8'h33: code = 5'd7;   8'h43: code = 5'd8;
            8'h3B: code = 5'd9;   8'h42: code = 5'd10;  8'h4B: code = 5'd11;
            8'h3A: code = 5'd12;  8'h31: code = 5'd13;  8'h44: code = 5'd14;
            8'h4D: code = 5'd15;  8'h15: code = 5'd16;  8'h2D: code = 5'd17;
            8'h1B: code = 5'd18;  8'h2C: code = 5'd19;  8'h3C: code = 5'd20;
            8'h2A: code = 5'd21;  8'h1D: code = 5'd22;  8'h22: code = 5'd23;
            8'h35: code = 5'd24;  8'h1A: code = 5'd25;
            default: is_letter = 1'b0;
        endcase
    end

    // Shift-based forms keep DIGITS=1 legal (no zero-width slices).
    always_comb begin
        push_n = (ents << 5) | EW'(code);
        pop_n  = (ents >> 5) | (EW'(BLANK) << (EW - 5));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ents        <= '1;
            count       <= '0;
            last_letter <= BLANK;
            letter_stb  <= 1'b0;
        end else begin
            letter_stb <= 1'b0;
            if (clr) begin
                ents        <= '1;
                count       <= '0;
                last_letter <= BLANK;
            end else if (do_letter) begin
                ents        <= push_n;
                last_letter <= code;
                letter_stb  <= 1'b1;
                if (count < 4'(DIGITS)) count <= count + 4'd1;
            end else if (do_bksp) begin
                ents        <= pop_n;
                last_letter <= pop_n[4:0];
                if (count != 4'd0) count <= count - 4'd1;
            end
        end
    end

    always_comb begin
        wrap  = (rcnt == RW'(REFRESH_DIV - 1));
        idx_n = idx;
        if (wrap) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt       <= '0;
            idx        <= '0;
            an         <= ~DIGITS'(1);
            digit_code <= BLANK;
        end else begin
            rcnt <= wrap ? '0 : rcnt + 1'b1;
            idx  <= idx_n;
            if (wrap) begin
                an         <= ~(DIGITS'(1) << idx_n);
                digit_code <= ents[5*32'(idx_n) +: 5];
            end
        end
    end

endmodule
